// File: rtl/up5bit_count_pkg.sv
// Shared types and Gray/binary conversion for the 5-bit up counter and its consumers.
package up5bit_count_pkg;

    localparam int unsigned CNT_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        SEED,
        TRACK,
        ERROR
    } mon_state_e;

    function automatic cnt_t bin2gray(input cnt_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic cnt_t gray2bin(input cnt_t g);
        cnt_t b;
        b[CNT_W-1] = g[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync_n.sv
// Multi-stage flop synchroniser for a Gray-coded bus crossing into clk.
module gray_sync_n #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/up5bit_gray_count_sync_monitor.sv
// Synchronises a foreign-domain Gray count, reports per-step advance, accumulates a saturating
// total and flags illegal jumps.
module up5bit_gray_count_sync_monitor
    import up5bit_count_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_STEP    = 1,
    parameter int unsigned TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   gray_in,
    input  logic               clear,
    output logic [CNT_W-1:0]   bin_out,
    output logic               step_valid,
    output logic [CNT_W-1:0]   step_size,
    output logic               wrap_pulse,
    output logic [TOTAL_W-1:0] total,
    output logic               err
);

    localparam logic [2:0] FILL = 3'(SYNC_STAGES);

    cnt_t gray_s;
    cnt_t bin_s;
    cnt_t delta;
    logic wrap;
    logic legal_step;
    logic illegal_jump;
    logic [31:0] delta_w;
    logic [TOTAL_W:0] total_sum;
    logic [TOTAL_W-1:0] total_sat;

    mon_state_e state_q, state_d;
    cnt_t prev_q, prev_d;
    cnt_t bin_out_q;
    logic step_valid_q, step_valid_d;
    cnt_t step_size_q, step_size_d;
    logic wrap_q, wrap_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic err_q, err_d;
    logic [2:0] fill_q;

    gray_sync_n #(
        .WIDTH  (CNT_W),
        .STAGES (SYNC_STAGES)
    ) u_gray_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gray_in),
        .q     (gray_s)
    );

    assign bin_s        = gray2bin(gray_s);
    assign delta        = bin_s - prev_q;
    assign wrap         = bin_s < prev_q;
    assign delta_w      = 32'(delta);
    assign legal_step   = (delta != '0) && (delta_w <= MAX_STEP);
    assign illegal_jump = delta_w > MAX_STEP;

    assign total_sum = {1'b0, total_q} + {{(TOTAL_W + 1 - CNT_W){1'b0}}, delta};
    assign total_sat = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        step_valid_d = 1'b0;
        step_size_d  = step_size_q;
        wrap_d       = 1'b0;
        total_d      = total_q;
        err_d        = err_q;

        if (clear) begin
            total_d = '0;
            err_d   = 1'b0;
            state_d = SEED;
        end else begin
            unique case (state_q)
                // After reset the synchroniser still holds its reset value; seed only once real
                // data has reached the last stage, otherwise the first sample looks like a jump.
                SEED: begin
                    if (fill_q == FILL) begin
                        prev_d  = bin_s;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (legal_step) begin
                        step_valid_d = 1'b1;
                        step_size_d  = delta;
                        wrap_d       = wrap;
                        prev_d       = bin_s;
                        total_d      = total_sat;
                    end else if (illegal_jump) begin
                        err_d   = 1'b1;
                        prev_d  = bin_s;
                        state_d = ERROR;
                    end
                end
                ERROR: begin
                    prev_d = bin_s;
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEED;
            prev_q       <= '0;
            bin_out_q    <= '0;
            step_valid_q <= 1'b0;
            step_size_q  <= '0;
            wrap_q       <= 1'b0;
            total_q      <= '0;
            err_q        <= 1'b0;
            fill_q       <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            bin_out_q    <= bin_s;
            step_valid_q <= step_valid_d;
            step_size_q  <= step_size_d;
            wrap_q       <= wrap_d;
            total_q      <= total_d;
            err_q        <= err_d;
            if (fill_q != FILL) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end

    assign bin_out    = bin_out_q;
    assign step_valid = step_valid_q;
    assign step_size  = step_size_q;
    assign wrap_pulse = wrap_q;
    assign total      = total_q;
    assign err        = err_q;

endmodule
